comparator_sequencer: RTL

Multi-cycle magnitude comparator controller. It compares two WIDTH-bit unsigned operands by stepping a single 2-bit compare slice (AgtB/AeqB/AltB semantics) across the operands, starting at the most significant pair. The block sits between a requesting datapath and the shared 2-bit compare logic. It provides a start/busy/done handshake and three registered one-hot result flags.

---
 rtl/comparator_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/comparator_sequencer.sv
// Multi-cycle unsigned magnitude comparator stepping a 2-bit slice MSB first.
// Define EARLY_EXIT_EN to stop on the first unequal slice instead of running all slices.
module comparator_sequencer #(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH/2+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             agtb,
    output logic             aeqb,
    output logic             altb,
    output logic [SW-1:0]    slices_used
);

    localparam int NS = WIDTH / 2;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic {
        IDLE,
        CMP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic             dec_q, dec_d;
    logic             gt_q, gt_d;
    logic             agtb_q, agtb_d;
    logic             aeqb_q, aeqb_d;
    logic             altb_q, altb_d;
    logic [SW-1:0]    slc_q, slc_d;
    logic             done_q, done_d;

    logic [1:0] sa, sb;
    logic       s_gt, s_eq;
    logic       last, leave;

    always_comb begin
        sa   = 2'(a_q >> {idx_q, 1'b0});
        sb   = 2'(b_q >> {idx_q, 1'b0});
        s_gt = sa > sb;
        s_eq = sa == sb;
        last = idx_q == '0;
`ifdef EARLY_EXIT_EN
        leave = last | ~s_eq;
`else
        leave = last;
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        gt_d    = gt_q;
        agtb_d  = agtb_q;
        aeqb_d  = aeqb_q;
        altb_d  = altb_q;
        slc_d   = slc_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IW'(NS - 1);
                    cnt_d   = '0;
                    dec_d   = 1'b0;
                    gt_d    = 1'b0;
                    agtb_d  = 1'b0;
                    aeqb_d  = 1'b0;
                    altb_d  = 1'b0;
                    state_d = CMP;
                end
            end
            CMP: begin
                cnt_d = cnt_q + SW'(1);
                // First unequal slice owns the result; later slices are ignored.
                if (!dec_q && !s_eq) begin
                    dec_d = 1'b1;
                    gt_d  = s_gt;
                end
                if (leave) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    slc_d   = cnt_q + SW'(1);
                    agtb_d  = dec_d & gt_d;
                    altb_d  = dec_d & ~gt_d;
                    aeqb_d  = ~dec_d;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            gt_q    <= 1'b0;
            agtb_q  <= 1'b0;
            aeqb_q  <= 1'b0;
            altb_q  <= 1'b0;
            slc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            gt_q    <= gt_d;
            agtb_q  <= agtb_d;
            aeqb_q  <= aeqb_d;
            altb_q  <= altb_d;
            slc_q   <= slc_d;
            done_q  <= done_d;
        end
    end

    assign busy        = state_q == CMP;
    assign done        = done_q;
    assign agtb        = agtb_q;
    assign aeqb        = aeqb_q;
    assign altb        = altb_q;
    assign slices_used = slc_q;

endmodule
